// File: rtl/noc_pkg.sv
// Shared Simple-NoC router definitions: port numbering, allocator states, flit framing.
// Used by switch_allocator and Buffer_Unit so both sides agree on tail encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = $clog2(NUM_PORTS);

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_e;

    // Bit 1 marks the last flit of a packet, so a single-flit packet is head+tail.
    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e ftype;
        port_idx_t  dest;
    } flit_hdr_t;

    function automatic logic is_tail(input flit_type_e t);
        return t[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after i_ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure (caller owns the pointer flop).
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[c]) begin
                w_found  = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator; grant is held until the owner's tail flit crosses.
// Grant one cycle after request, release one cycle after tail; a paused owner keeps the output.
module switch_allocator #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS*PORT_W-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]        flit_sent_i,
    input  logic [NUM_PORTS-1:0]        tail_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic [NUM_PORTS*PORT_W-1:0] xbar_sel_o,
    output logic [NUM_PORTS-1:0]        xbar_valid_o
);

    import noc_pkg::*;

    logic [NUM_PORTS-1:0] w_grant;

    // Decoded from the per-output state/owner flops only, so no input reaches an output.
    always_comb begin
        w_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (xbar_valid_o[o] && (xbar_sel_o[o*PORT_W +: PORT_W] == PORT_W'(i)))
                    w_grant[i] = 1'b1;
            end
        end
    end

    assign grant_o = w_grant;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [NUM_PORTS-1:0] w_req;
        logic [NUM_PORTS-1:0] w_arb_gnt;
        logic [PORT_W-1:0]    w_arb_idx;
        logic [PORT_W-1:0]    r_owner;
        logic [PORT_W-1:0]    r_ptr;
        sa_state_e            r_state;

        // Out-of-range destinations never match any output index.
        always_comb begin
            w_req = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                w_req[i] = req_i[i] && (dest_i[i*PORT_W +: PORT_W] == PORT_W'(o)) && !w_grant[i];
        end

        rr_arbiter #(
            .N     (NUM_PORTS),
            .PTR_W (PORT_W)
        ) u_arb (
            .i_req (w_req),
            .i_ptr (r_ptr),
            .o_gnt (w_arb_gnt),
            .o_idx (w_arb_idx)
        );

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state <= SA_IDLE;
                r_owner <= '0;
                r_ptr   <= PORT_W'(NUM_PORTS - 1);
            end else begin
                case (r_state)
                    SA_IDLE: begin
                        if (|w_arb_gnt) begin
                            r_state <= SA_LOCKED;
                            r_owner <= w_arb_idx;
                        end
                    end
                    SA_LOCKED: begin
                        // Releasing owner becomes the pointer, giving it lowest priority next round.
                        if (flit_sent_i[r_owner] && tail_i[r_owner]) begin
                            r_state <= SA_IDLE;
                            r_ptr   <= r_owner;
                        end
                    end
                    default: r_state <= SA_IDLE;
                endcase
            end
        end

        assign xbar_valid_o[o]                   = (r_state == SA_LOCKED);
        assign xbar_sel_o[o*PORT_W +: PORT_W]    = r_owner;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, single grant, round-robin, lock hold, parallel, edge cases.
module tb_switch_allocator;
    import noc_pkg::*;

    localparam int NP = NUM_PORTS;
    localparam int PW = PORT_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      req;
    logic [NP*PW-1:0]   dest;
    logic [NP-1:0]      flit_sent;
    logic [NP-1:0]      tail;
    logic [NP-1:0]      grant;
    logic [NP*PW-1:0]   xbar_sel;
    logic [NP-1:0]      xbar_valid;

    int checks = 0;
    int errors = 0;

    switch_allocator #(
        .NUM_PORTS (NP),
        .PORT_W    (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .dest_i       (dest),
        .flit_sent_i  (flit_sent),
        .tail_i       (tail),
        .grant_o      (grant),
        .xbar_sel_o   (xbar_sel),
        .xbar_valid_o (xbar_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int i, input logic [PW-1:0] d);
        dest[i*PW +: PW] = d;
    endtask

    function automatic logic [PW-1:0] sel_of(input int o);
        return xbar_sel[o*PW +: PW];
    endfunction

    task automatic apply_reset();
        rst = 1'b0; req = '0; dest = '0; flit_sent = '0; tail = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 5'b11111; flit_sent = '0; tail = '0;
        for (int i = 0; i < NP; i++) set_dest(i, NORTH);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (grant !== 5'b00000) begin
                errors++; $display("FAIL reset_grant cyc %0d got %b exp 00000", c, grant);
            end
            checks++;
            if (xbar_valid !== 5'b00000) begin
                errors++; $display("FAIL reset_valid cyc %0d got %b exp 00000", c, xbar_valid);
            end
        end
        checks++;
        if (xbar_sel !== 15'h0000) begin
            errors++; $display("FAIL reset_sel got %h exp 0000", xbar_sel);
        end
        rst = 1'b1;
        step();
        checks++;
        if (grant !== 5'b00001) begin
            errors++; $display("FAIL reset_first_grant got %b exp 00001", grant);
        end
        checks++;
        if (xbar_valid !== 5'b00010) begin
            errors++; $display("FAIL reset_first_valid got %b exp 00010", xbar_valid);
        end
        req = '0; flit_sent = 5'b00001; tail = 5'b00001;
        step();
        flit_sent = '0; tail = '0;
        checks++;
        if (grant !== 5'b00000) begin
            errors++; $display("FAIL reset_release got %b exp 00000", grant);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 5'b00100; set_dest(2, EAST);
        step();
        checks++;
        if (grant !== 5'b00100) begin
            errors++; $display("FAIL single_grant got %b exp 00100", grant);
        end
        checks++;
        if (sel_of(EAST) !== 3'd2) begin
            errors++; $display("FAIL single_sel got %0d exp 2", sel_of(EAST));
        end
        checks++;
        if (xbar_valid !== 5'b00100) begin
            errors++; $display("FAIL single_valid got %b exp 00100", xbar_valid);
        end
        req = '0; flit_sent = 5'b00100; tail = 5'b00100;
        step();
        flit_sent = '0; tail = '0;
        checks++;
        if (grant !== 5'b00000) begin
            errors++; $display("FAIL single_release got %b exp 00000", grant);
        end
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 3, 0};
        logic [NP-1:0] exp_g;
        apply_reset();
        req = 5'b01011;
        set_dest(0, NORTH); set_dest(1, NORTH); set_dest(3, NORTH);
        for (int n = 0; n < 4; n++) begin
            exp_g = 5'b00001 << order[n];
            step();
            checks++;
            if (grant !== exp_g || sel_of(NORTH) !== PW'(order[n])) begin
                errors++; $display("FAIL rr_grant pkt %0d got %b sel %0d exp %b sel %0d",
                                   n, grant, sel_of(NORTH), exp_g, order[n]);
            end
            flit_sent = exp_g; tail = '0;
            step();
            checks++;
            if (grant !== exp_g) begin
                errors++; $display("FAIL rr_hold pkt %0d got %b exp %b", n, grant, exp_g);
            end
            tail = exp_g;
            step();
            flit_sent = '0; tail = '0;
            checks++;
            if (grant !== 5'b00000 || xbar_valid[NORTH] !== 1'b0) begin
                errors++; $display("FAIL rr_bubble pkt %0d got %b valid %b exp 00000 valid 0",
                                   n, grant, xbar_valid);
            end
        end
        req = '0;
    endtask

    task automatic test_lock_hold();
        apply_reset();
        req = 5'b10000; set_dest(4, WEST);
        step();
        checks++;
        if (grant !== 5'b10000) begin
            errors++; $display("FAIL lock_grant got %b exp 10000", grant);
        end
        req = 5'b00010; set_dest(1, WEST);
        for (int c = 0; c < 3; c++) begin
            // Sends from the ungranted input must not release anything.
            if (c == 2) begin flit_sent = 5'b00010; tail = 5'b00010; end
            step();
            checks++;
            if (grant !== 5'b10000 || sel_of(WEST) !== 3'd4) begin
                errors++; $display("FAIL lock_hold cyc %0d got %b sel %0d exp 10000 sel 4",
                                   c, grant, sel_of(WEST));
            end
        end
        flit_sent = 5'b10000; tail = 5'b10000;
        step();
        flit_sent = '0; tail = '0;
        checks++;
        if (grant !== 5'b00000) begin
            errors++; $display("FAIL lock_release got %b exp 00000", grant);
        end
        step();
        checks++;
        if (grant !== 5'b00010 || sel_of(WEST) !== 3'd1) begin
            errors++; $display("FAIL lock_next got %b sel %0d exp 00010 sel 1", grant, sel_of(WEST));
        end
        req = '0; flit_sent = 5'b00010; tail = 5'b00010;
        step();
        flit_sent = '0; tail = '0;
    endtask

    task automatic test_parallel();
        apply_reset();
        req = 5'b01001; set_dest(0, SOUTH); set_dest(3, LOCAL);
        step();
        checks++;
        if (grant !== 5'b01001) begin
            errors++; $display("FAIL par_grant got %b exp 01001", grant);
        end
        checks++;
        if (xbar_valid !== 5'b01001) begin
            errors++; $display("FAIL par_valid got %b exp 01001", xbar_valid);
        end
        checks++;
        if (sel_of(SOUTH) !== 3'd0 || sel_of(LOCAL) !== 3'd3) begin
            errors++; $display("FAIL par_sel got south %0d local %0d exp south 0 local 3",
                               sel_of(SOUTH), sel_of(LOCAL));
        end
        req = '0; flit_sent = 5'b01001; tail = 5'b01001;
        step();
        flit_sent = '0; tail = '0;
    endtask

    task automatic test_bad_dest();
        apply_reset();
        req = 5'b00100; set_dest(2, 3'd7);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (grant !== 5'b00000 || xbar_valid !== 5'b00000) begin
                errors++; $display("FAIL bad_dest cyc %0d got %b valid %b exp 00000", c, grant, xbar_valid);
            end
        end
        req = '0;
    endtask

    task automatic test_single_flit();
        apply_reset();
        req = 5'b00010; set_dest(1, EAST);
        step();
        checks++;
        if (grant !== 5'b00010) begin
            errors++; $display("FAIL sflit_grant got %b exp 00010", grant);
        end
        req = '0; flit_sent = 5'b00010; tail = 5'b00010;
        step();
        flit_sent = '0; tail = '0;
        checks++;
        if (grant !== 5'b00000 || xbar_valid[EAST] !== 1'b0) begin
            errors++; $display("FAIL sflit_release got %b valid %b exp 00000", grant, xbar_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 5'b01001; set_dest(0, EAST); set_dest(3, WEST);
        step();
        flit_sent = 5'b01001;
        step();
        checks++;
        if (grant !== 5'b01001) begin
            errors++; $display("FAIL midrst_pre got %b exp 01001", grant);
        end
        rst = 1'b0;
        step();
        checks++;
        if (grant !== 5'b00000 || xbar_valid !== 5'b00000) begin
            errors++; $display("FAIL midrst_clear got %b valid %b exp 00000", grant, xbar_valid);
        end
        rst = 1'b1; req = '0; flit_sent = '0;
        step();
    endtask

    initial begin
        rst = 1'b0; req = '0; dest = '0; flit_sent = '0; tail = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_hold();
        test_parallel();
        test_bad_dest();
        test_single_flit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
